// File: rtl/line_window_buffer.sv
// line_window_buffer: a ring of NUM_LINES+1 line banks. One bank fills from the pixel stream
// while the other NUM_LINES stream out column by column as a vertical window.
// Build option LWB_STALL_CNT_EN adds the stall_cnt output (saturating input-stall cycle count).
module line_window_buffer #(
    parameter int NUM_LINES  = 3,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 1,
    parameter int MAX_COLS   = 1024,
    parameter int COL_W      = $clog2(MAX_COLS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [COL_W:0]                        cfg_cols,
    input  logic                                  frame_start,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          s_data,
    input  logic                                  s_eol,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [NUM_LINES*NUM_CH*DATA_WIDTH-1:0] m_data,
    output logic [COL_W-1:0]                      m_col,
    output logic                                  m_last,
    output logic                                  err_len,
    output logic [1:0]                            rd_state_dbg
`ifdef LWB_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cnt
`endif
);
    localparam int NB     = NUM_LINES + 1;
    localparam int BANK_W = $clog2(NB);
    localparam int FL_W   = $clog2(NB + 1);
    localparam int PW     = NUM_CH * DATA_WIDTH;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_RUN = 2'd1, R_RETIRE = 2'd2} rd_state_t;

    // Handshakes: a beat transfers on a rising clk edge where valid && ready. Once m_valid is
    // high, m_data/m_col/m_last hold until that transfer; only frame_start or reset may drop it.
    logic [PW-1:0]           mem [NB][MAX_COLS];
    logic [PW-1:0]           bank_q [NB];
    logic [COL_W:0]          cfg_q, cols_m1;
    logic [COL_W-1:0]        wr_col, rd_col, s1_col;
    logic [BANK_W-1:0]       wr_bank, rd_base;
    logic [FL_W-1:0]         full_lines;
    rd_state_t               rd_state, rd_state_n;
    logic                    restart, wr_en, wr_last_col, line_done, retire;
    logic                    rd_en, rd_last_col, issue_done, pipe_en, s1_valid, s1_last;
    logic [NUM_LINES*PW-1:0] win_data;
    logic [BANK_W:0]         idx;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NB - 1)) ? '0 : b + 1'b1;
    endfunction

    assign restart      = reset || frame_start;
    assign cols_m1      = cfg_q - (COL_W + 1)'(1);
    assign s_ready      = !restart && (full_lines < FL_W'(NB));
    assign wr_en        = s_valid && s_ready;
    assign wr_last_col  = ({1'b0, wr_col} == cols_m1);
    assign line_done    = wr_en && (s_eol || wr_last_col);
    assign retire       = (rd_state == R_RETIRE);
    assign rd_last_col  = ({1'b0, rd_col} == cols_m1);
    assign s1_last      = ({1'b0, s1_col} == cols_m1);
    assign pipe_en      = !m_valid || m_ready;
    assign rd_state_dbg = rd_state;

    // Write side: fill the current bank, advance the ring when a line completes.
    always_ff @(posedge clk) begin
        if (restart) begin
            cfg_q      <= cfg_cols;
            wr_col     <= '0;
            wr_bank    <= '0;
            full_lines <= '0;
            err_len    <= 1'b0;
        end else begin
            err_len <= wr_en && (s_eol != wr_last_col);
            if (line_done) begin
                wr_col  <= '0;
                wr_bank <= bank_inc(wr_bank);
            end else if (wr_en) begin
                wr_col <= wr_col + 1'b1;
            end
            if (line_done && !retire)
                full_lines <= full_lines + 1'b1;
            else if (!line_done && retire)
                full_lines <= full_lines - 1'b1;
        end
    end

    // Bank storage: one write port, every bank read at the same column.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_col] <= s_data;
        if (rd_en)
            for (int b = 0; b < NB; b++)
                bank_q[b] <= mem[b][rd_col];
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_en      = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (full_lines >= FL_W'(NUM_LINES)) begin
                    rd_state_n = R_RUN;
                    rd_en      = pipe_en;
                end
            end
            R_RUN: begin
                rd_en = pipe_en && !issue_done;
                if (m_valid && m_ready && m_last)
                    rd_state_n = R_RETIRE;
            end
            R_RETIRE: rd_state_n = R_IDLE;
            default:  rd_state_n = R_IDLE;
        endcase
    end

    // Oldest window line lands in the least significant slice.
    always_comb begin
        win_data = '0;
        idx      = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            idx = {1'b0, rd_base} + (BANK_W + 1)'(i);
            if (idx >= (BANK_W + 1)'(NB))
                idx = idx - (BANK_W + 1)'(NB);
            win_data[i*PW +: PW] = bank_q[idx[BANK_W-1:0]];
        end
    end

    // Read side: issue -> bank register -> output register, all advancing on pipe_en.
    always_ff @(posedge clk) begin
        if (restart) begin
            rd_state   <= R_IDLE;
            rd_base    <= '0;
            rd_col     <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_col     <= '0;
            m_valid    <= 1'b0;
            m_col      <= '0;
            m_last     <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            if (retire) begin
                rd_base    <= bank_inc(rd_base);
                rd_col     <= '0;
                issue_done <= 1'b0;
            end else if (rd_en) begin
                if (rd_last_col)
                    issue_done <= 1'b1;
                else
                    rd_col <= rd_col + 1'b1;
            end
            if (pipe_en) begin
                s1_valid <= rd_en;
                s1_col   <= rd_col;
                m_valid  <= s1_valid;
                m_col    <= s1_col;
                m_last   <= s1_valid && s1_last;
                m_data   <= win_data;
            end
        end
    end

`ifdef LWB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (restart)
            stall_cnt <= '0;
        else if (s_valid && !s_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: bank/line reference model feeds an expected-beat
// queue; a negedge monitor pops and compares each accepted window column.
module tb_line_window_buffer;
  localparam int NL = 3;
  localparam int DW = 16;
  localparam int MC = 1024;
  localparam int CW = 10;
  localparam int NB = NL + 1;
  localparam int MW = NL * DW;
  localparam int EW = 1 + CW + MW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW:0]   cfg_cols = 11'd8;
  logic          frame_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_eol = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [MW-1:0] m_data;
  logic [CW-1:0] m_col;
  logic          m_last;
  logic          err_len;
  logic [1:0]    rd_state_dbg;
`ifdef LWB_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  line_window_buffer dut (
    .clk(clk), .reset(reset), .cfg_cols(cfg_cols), .frame_start(frame_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col),
    .m_last(m_last), .err_len(err_len), .rd_state_dbg(rd_state_dbg)
`ifdef LWB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;
  int stalls_m = 0;
  int m_cols = 8;
  int m_wr_col = 0;
  int m_lines = 0;
  logic [DW-1:0] bank_m [NB][MC];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_beat, exp_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted window column must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_len === 1'b1) err_seen++;
      if (s_valid && !s_ready) stalls_m++;
      if (m_valid && m_ready) begin
        act_beat = {m_last, m_col, m_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected actual=0x%0h required=none", act_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          if (act_beat !== exp_beat) begin
            failures++;
            $display("FAIL beat actual=0x%0h required=0x%0h", act_beat, exp_beat);
          end
        end
      end
    end
  end

  task automatic model_clear(input int cols);
    m_cols = cols; m_wr_col = 0; m_lines = 0;
    err_seen = 0; err_exp = 0; stalls_m = 0;
    exp_q.delete();
  endtask

  // Pass p reads lines p..p+NL-1; line k lives in bank k mod NB.
  task automatic push_pass(input int p);
    logic [MW-1:0] d;
    for (int c = 0; c < m_cols; c++) begin
      for (int i = 0; i < NL; i++) d[i*DW +: DW] = bank_m[(p + i) % NB][c];
      exp_q.push_back({(c == m_cols - 1), CW'(c), d});
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input bit eol);
    bit last_col;
    bank_m[m_lines % NB][m_wr_col] = d;
    last_col = (m_wr_col == m_cols - 1);
    if (eol != last_col) err_exp++;
    if (eol || last_col) begin
      m_wr_col = 0;
      m_lines++;
      if (m_lines >= NL) push_pass(m_lines - NL);
    end else begin
      m_wr_col++;
    end
  endtask

  task automatic do_reset(input int cols, input bit also_fs);
    reset = 1'b1; frame_start = also_fs; cfg_cols = (CW+1)'(cols);
    s_valid = 1'b0; s_eol = 1'b0;
    @(negedge clk);
    check("s_ready_in_reset", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0; frame_start = 1'b0;
    model_clear(cols);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_col", 64'(m_col), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_err_len", 64'(err_len), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  // Drive one row; eol_at < 0 means no eol. Called and returns at posedge+1.
  task automatic send_line(input int row, input int n, input int eol_at, input bit rnd,
                           input int gap_max);
    logic [DW-1:0] d;
    bit acc;
    int waited;
    for (int c = 0; c < n; c++) begin
      d = rnd ? DW'($urandom) : DW'(row * 16 + c);
      repeat ($urandom_range(0, gap_max)) begin
        s_valid = 1'b0; @(posedge clk); #1;
      end
      s_valid = 1'b1; s_data = d; s_eol = (c == eol_at);
      acc = 1'b0; waited = 0;
      while (!acc && waited < 20000) begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1; waited++;
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL s_accept_timeout actual=not_accepted required=accepted row=%0d col=%0d", row, c);
        s_valid = 1'b0; s_eol = 1'b0;
        return;
      end
      model_accept(d, c == eol_at);
    end
    s_valid = 1'b0; s_eol = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 20000) begin
      @(posedge clk); #1; budget++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    repeat (4) @(posedge clk); #1;
  endtask

  // toggle=1: m_ready alternates each cycle; toggle=0: m_ready random.
  task automatic run_rows(input int first_row, input int rows, input int cols, input bit toggle,
                          input bit rnd, input int gap_max);
    bit send_done;
    send_done = 1'b0;
    m_ready = 1'b1;
    fork
      begin
        for (int r = 0; r < rows; r++) send_line(first_row + r, cols, cols - 1, rnd, gap_max);
        send_done = 1'b1;
      end
      begin
        int cnt;
        cnt = 0;
        while (!(send_done && exp_q.size() == 0) && cnt < 30000) begin
          @(posedge clk); #1;
          m_ready = toggle ? !m_ready : 1'($urandom_range(0, 1));
          cnt++;
        end
      end
    join
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cols;
    for (int b = 0; b < NB; b++) for (int c = 0; c < MC; c++) bank_m[b][c] = '0;

    // Basic two passes, eol on column 7
    do_reset(8, 1'b0);
    m_ready = 1'b1;
    for (int r = 0; r < 4; r++) send_line(r, 8, 7, 1'b0, 0);
    drain("t1_drain");
    check("t1_err", 64'(err_seen), 64'(err_exp));

    // Backpressure: consumer stalled, ring fills, row 4 waits for a retire
    do_reset(8, 1'b0);
    m_ready = 1'b0;
    for (int r = 0; r < 4; r++) send_line(r, 8, 7, 1'b0, 0);
    @(negedge clk);
    check("t2_s_ready_full", 64'(s_ready), 64'(0));
    check("t2_m_valid_held", 64'(m_valid), 64'(1));
    @(posedge clk); #1;
    fork
      send_line(4, 8, 7, 1'b0, 0);
      begin
        repeat (5) @(negedge clk);
        check("t2_m_data_frozen", 64'(m_data), 64'({16'h0020, 16'h0010, 16'h0000}));
        check("t2_m_col_frozen", 64'(m_col), 64'(0));
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain("t2_drain");
`ifdef LWB_STALL_CNT_EN
    check("t2_stall_cnt", 64'(stall_cnt), 64'(stalls_m));
`endif

    // Line-length errors: early eol, then a full row with no eol
    do_reset(8, 1'b0);
    m_ready = 1'b1;
    send_line(0, 6, 5, 1'b0, 0);
    repeat (2) @(posedge clk); #1;
    check("t3_err_early_eol", 64'(err_seen), 64'(err_exp));
    send_line(1, 8, 7, 1'b0, 0);
    send_line(2, 8, 7, 1'b0, 0);
    send_line(3, 8, -1, 1'b0, 0);
    drain("t3_drain");
    check("t3_err_total", 64'(err_seen), 64'(err_exp));

    // m_ready toggling every cycle during passes
    do_reset(8, 1'b0);
    run_rows(8, 4, 8, 1'b1, 1'b0, 1);
    drain("t4_drain");
    check("t4_err", 64'(err_seen), 64'(err_exp));

    // frame_start at pass column 4, then fresh rows 5..7
    do_reset(8, 1'b0);
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_line(r, 8, 7, 1'b0, 0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_valid && m_col == CW'(4)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("t5_reach_col4", 64'(found), 64'(1));
    m_ready = 1'b0; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    model_clear(8);
    @(negedge clk);
    check("t5_m_valid_drop", 64'(m_valid), 64'(0));
    check("t5_m_col_clear", 64'(m_col), 64'(0));
    check("t5_s_ready_after", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int r = 5; r < 8; r++) send_line(r, 8, 7, 1'b0, 0);
    drain("t5_drain");
    check("t5_err", 64'(err_seen), 64'(err_exp));

    // reset + frame_start together mid-line, line length shrinks to 4
    do_reset(8, 1'b0);
    m_ready = 1'b1;
    send_line(0, 4, -1, 1'b0, 0);
    do_reset(4, 1'b1);
    for (int r = 0; r < 4; r++) send_line(r, 4, 3, 1'b0, 0);
    drain("t6_drain");
    check("t6_err", 64'(err_seen), 64'(err_exp));

    // Random data, random gaps and random m_ready at 1, random and maximum line length
    for (int t = 0; t < 3; t++) begin
      cols = (t == 0) ? 1 : (t == 1) ? int'($urandom_range(2, 16)) : MC;
      do_reset(cols, 1'b0);
      run_rows(0, (t == 2) ? 4 : 6, cols, 1'b0, 1'b1, 2);
      drain("t7_drain");
      check("t7_err", 64'(err_seen), 64'(err_exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
